// File: rtl/joybus_tx_multi.sv
// Joybus console-side transmitter: serialises a 1..MAX_BYTES command frame, adds a stop bit,
// then releases the line until rx_done. Optional response timeout: JOYBUS_TX_TIMEOUT_EN.
module joybus_tx_multi #(
  parameter int MAX_BYTES    = 3,
  parameter int QUARTER_CYC  = 25,
  parameter int RESP_TIMEOUT = 5000,
  localparam int LW          = $clog2(MAX_BYTES + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [8*MAX_BYTES-1:0] cmd_data,
  input  logic [LW-1:0]          cmd_len,
  input  logic                   cmd_rdy,
  input  logic                   rx_done,
  output logic                   JB_TX,
  output logic                   JB_TX_SEL,
  output logic                   tx_done,
  output logic                   busy,
  output logic                   cmd_err,
  output logic                   timeout
);

  localparam int QW = $clog2(QUARTER_CYC + 1);

  typedef enum logic [1:0] {IDLE, BIT, STOP, WAIT_RX} state_t;

  state_t                 state_q, state_d;
  logic [8*MAX_BYTES-1:0] data_q, data_d;
  logic [LW-1:0]          len_q, len_d;
  logic [LW-1:0]          byte_q, byte_d;
  logic [2:0]             bit_q, bit_d;
  logic [1:0]             qtr_q, qtr_d;
  logic [QW-1:0]          qcnt_q, qcnt_d;
  logic                   jb_tx_q, jb_tx_d;
  logic                   sel_q, sel_d;
  logic                   tx_done_q, tx_done_d;
  logic                   busy_q, busy_d;
  logic                   cmd_err_q, cmd_err_d;
  logic                   bit_val;
  logic                   len_ok;

`ifdef JOYBUS_TX_TIMEOUT_EN
  localparam int TW = $clog2(RESP_TIMEOUT + 1);
  logic [TW-1:0] wait_q, wait_d;
  logic          timeout_q, timeout_d;
`endif

  function automatic logic frame_bit(input logic [8*MAX_BYTES-1:0] data,
                                     input logic [LW-1:0] byte_idx,
                                     input logic [2:0] bit_idx);
    logic [8*MAX_BYTES-1:0] sh;
    sh = data >> {byte_idx, 3'b000};
    return sh[bit_idx];
  endfunction

  assign len_ok = (cmd_len != '0) && ({1'b0, cmd_len} <= (LW+1)'(MAX_BYTES));

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    len_d     = len_q;
    byte_d    = byte_q;
    bit_d     = bit_q;
    qtr_d     = qtr_q;
    qcnt_d    = qcnt_q;
    cmd_err_d = 1'b0;
`ifdef JOYBUS_TX_TIMEOUT_EN
    wait_d    = wait_q;
    timeout_d = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (cmd_rdy) begin
          if (len_ok) begin
            state_d = BIT;
            data_d  = cmd_data;
            len_d   = cmd_len;
            byte_d  = '0;
            bit_d   = 3'd7;
            qtr_d   = 2'd0;
            qcnt_d  = '0;
          end else begin
            cmd_err_d = 1'b1;
          end
        end
      end
      BIT: begin
        if (qcnt_q == QW'(QUARTER_CYC - 1)) begin
          qcnt_d = '0;
          qtr_d  = qtr_q + 2'd1;
          if (qtr_q == 2'd3) begin
            bit_d = bit_q - 3'd1;
            if (bit_q == 3'd0) begin
              if (byte_q == len_q - LW'(1)) state_d = STOP;
              else byte_d = byte_q + LW'(1);
            end
          end
        end else begin
          qcnt_d = qcnt_q + QW'(1);
        end
      end
      STOP: begin
        if (qcnt_q == QW'(QUARTER_CYC - 1)) begin
          qcnt_d = '0;
          qtr_d  = qtr_q + 2'd1;
          if (qtr_q == 2'd2) begin
            state_d = WAIT_RX;
`ifdef JOYBUS_TX_TIMEOUT_EN
            wait_d  = '0;
`endif
          end
        end else begin
          qcnt_d = qcnt_q + QW'(1);
        end
      end
      default: begin
        if (rx_done) begin
          state_d = IDLE;
`ifdef JOYBUS_TX_TIMEOUT_EN
        end else if (wait_q == TW'(RESP_TIMEOUT - 1)) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end else begin
          wait_d = wait_q + TW'(1);
`endif
        end
      end
    endcase

    // Outputs are registered, so they are derived from the next state and counters.
    bit_val = frame_bit(data_d, byte_d, bit_d);
    unique case (state_d)
      BIT:     jb_tx_d = !((qtr_d == 2'd0) || ((qtr_d != 2'd3) && !bit_val));
      STOP:    jb_tx_d = (qtr_d != 2'd0);
      default: jb_tx_d = 1'b1;
    endcase
    sel_d     = (state_d == BIT) || (state_d == STOP);
    busy_d    = (state_d != IDLE);
    tx_done_d = (state_q == STOP) && (state_d == WAIT_RX);
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
    len_q  <= len_d;
    if (rst) begin
      state_q   <= IDLE;
      byte_q    <= '0;
      bit_q     <= 3'd7;
      qtr_q     <= 2'd0;
      qcnt_q    <= '0;
      jb_tx_q   <= 1'b1;
      sel_q     <= 1'b0;
      tx_done_q <= 1'b0;
      busy_q    <= 1'b0;
      cmd_err_q <= 1'b0;
`ifdef JOYBUS_TX_TIMEOUT_EN
      wait_q    <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      byte_q    <= byte_d;
      bit_q     <= bit_d;
      qtr_q     <= qtr_d;
      qcnt_q    <= qcnt_d;
      jb_tx_q   <= jb_tx_d;
      sel_q     <= sel_d;
      tx_done_q <= tx_done_d;
      busy_q    <= busy_d;
      cmd_err_q <= cmd_err_d;
`ifdef JOYBUS_TX_TIMEOUT_EN
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign JB_TX     = jb_tx_q;
  assign JB_TX_SEL = sel_q;
  assign tx_done   = tx_done_q;
  assign busy      = busy_q;
  assign cmd_err   = cmd_err_q;
`ifdef JOYBUS_TX_TIMEOUT_EN
  assign timeout   = timeout_q;
`else
  assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_joybus_tx_multi.sv
// Bench for joybus_tx_multi: randomised frames checked cycle by cycle against a waveform model
// derived from the bit timing rules, plus decoded-bit, length-error and mid-frame reset checks.
module tb_joybus_tx_multi;

  localparam int Q = 4;

  logic        clk;
  logic        rst;
  logic [23:0] cmd_data;
  logic [1:0]  cmd_len;
  logic        cmd_rdy, rx_done;
  logic        JB_TX, JB_TX_SEL, tx_done, busy, cmd_err, timeout;

  logic [15:0] cmd_data2;
  logic [1:0]  cmd_len2;
  logic        cmd_rdy2;
  logic        JB_TX2, JB_TX_SEL2, tx_done2, busy2, cmd_err2, timeout2;

  int checks = 0;
  int errors = 0;

  joybus_tx_multi #(.MAX_BYTES(3), .QUARTER_CYC(Q), .RESP_TIMEOUT(100)) u_dut (
    .clk(clk), .rst(rst), .cmd_data(cmd_data), .cmd_len(cmd_len), .cmd_rdy(cmd_rdy),
    .rx_done(rx_done), .JB_TX(JB_TX), .JB_TX_SEL(JB_TX_SEL), .tx_done(tx_done),
    .busy(busy), .cmd_err(cmd_err), .timeout(timeout)
  );

  // Two-byte variant so that an over-length cmd_len (3) is representable.
  joybus_tx_multi #(.MAX_BYTES(2), .QUARTER_CYC(Q), .RESP_TIMEOUT(100)) u_dut2 (
    .clk(clk), .rst(rst), .cmd_data(cmd_data2), .cmd_len(cmd_len2), .cmd_rdy(cmd_rdy2),
    .rx_done(1'b0), .JB_TX(JB_TX2), .JB_TX_SEL(JB_TX_SEL2), .tx_done(tx_done2),
    .busy(busy2), .cmd_err(cmd_err2), .timeout(timeout2)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  function automatic logic [5:0] obs();
    return {JB_TX_SEL, JB_TX, tx_done, busy, cmd_err, timeout};
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Line level at offset i of the owned window: low 1Q for a '1', 3Q for a '0'; stop low 1Q.
  function automatic logic exp_tx(input logic [23:0] d, input int n, input int i);
    int bi, pos;
    logic v;
    bi  = i / (4*Q);
    pos = i % (4*Q);
    if (bi < n*8) begin
      v = d[(bi/8)*8 + 7 - (bi%8)];
      return pos >= (v ? Q : 3*Q);
    end
    return (i - n*32*Q) >= Q;
  endfunction

  task automatic run_frame(input logic [23:0] d, input int n, input int rx_delay,
                           input int repulse_at, output logic [23:0] dec);
    int total, nbits, lowcnt, selcnt;
    logic [23:0] expbits;
    total   = n*32*Q + 3*Q;
    dec     = '0;
    expbits = '0;
    nbits   = 0;
    lowcnt  = 0;
    selcnt  = 0;
    for (int k = 0; k < n*8; k++) expbits = {expbits[22:0], d[(k/8)*8 + 7 - (k%8)]};
    cmd_data = d;
    cmd_len  = 2'(n);
    cmd_rdy  = 1'b1;
    tick();
    cmd_rdy  = 1'b0;
    cmd_data = $urandom;
    cmd_len  = 2'($urandom_range(1, 3));
    for (int i = 0; i < total; i++) begin
      chk("frame", 32'(obs()), 32'({1'b1, exp_tx(d, n, i), 4'b0100}));
      if (JB_TX_SEL) selcnt++;
      if (!JB_TX) lowcnt++;
      else if (lowcnt > 0) begin
        if (nbits < n*8) begin
          dec = {dec[22:0], lowcnt <= 2*Q};
          nbits++;
        end
        lowcnt = 0;
      end
      cmd_rdy = (i == repulse_at);
      rx_done = (i < total - 1) && ($urandom_range(0, 7) == 0);
      tick();
    end
    cmd_rdy = 1'b0;
    rx_done = 1'b0;
    chk("sel_len", 32'(selcnt), 32'(total));
    chk("bits", 32'(dec), 32'(expbits));
    chk("tx_done", 32'(obs()), 32'(6'b011100));
    if (rx_delay < 0) return;
    for (int j = 0; j < rx_delay; j++) begin
      tick();
      chk("wait_rx", 32'(obs()), 32'(6'b010100));
    end
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    chk("idle_after_rx", 32'(obs()), 32'(6'b010000));
  endtask

  initial begin
    logic [23:0] dec;
    int n, tot;
    rst = 1'b1; cmd_rdy = 1'b0; rx_done = 1'b0; cmd_data = '0; cmd_len = '0;
    cmd_rdy2 = 1'b0; cmd_data2 = '0; cmd_len2 = '0;
    tick();
    tick();
    chk("reset", 32'(obs()), 32'(6'b010000));
    rst = 1'b0;
    tick();

    run_frame(24'h0000AA, 1, 10, 20, dec);
    chk("aa_bits", 32'(dec), 32'h0000AA);

    run_frame(24'h000340, 3, 0, 200, dec);
    chk("gc_poll_bits", 32'(dec), 32'h400300);

    for (int r = 0; r < 4; r++) begin
      n   = $urandom_range(1, 3);
      tot = n*32*Q + 3*Q;
      run_frame(24'($urandom), n, $urandom_range(0, 20), $urandom_range(0, tot - 2), dec);
    end

    cmd_len = 2'd0; cmd_data = 24'h123456; cmd_rdy = 1'b1;
    tick();
    cmd_rdy = 1'b0;
    chk("err_len0", 32'(obs()), 32'(6'b010010));
    tick();
    chk("err_len0_after", 32'(obs()), 32'(6'b010000));

    cmd_len2 = 2'd3; cmd_data2 = 16'hBEEF; cmd_rdy2 = 1'b1;
    tick();
    cmd_rdy2 = 1'b0;
    chk("err_len_over", 32'({JB_TX_SEL2, JB_TX2, busy2, cmd_err2}), 32'(4'b0101));
    tick();
    chk("err_len_over_after", 32'({JB_TX_SEL2, JB_TX2, busy2, cmd_err2}), 32'(4'b0100));

    cmd_data = 24'h00C3F0; cmd_len = 2'd2; cmd_rdy = 1'b1;
    tick();
    cmd_rdy = 1'b0;
    for (int i = 1; i < 50; i++) tick();
    chk("mid_frame_sel", 32'(JB_TX_SEL), 32'(1));
    rst = 1'b1;
    tick();
    chk("mid_frame_reset", 32'(obs()), 32'(6'b010000));
    rst = 1'b0;
    tick();
    run_frame(24'h5A_81_3C, 3, 5, -1, dec);

`ifdef JOYBUS_TX_TIMEOUT_EN
    run_frame(24'h000055, 1, -1, -1, dec);
    for (int j = 1; j < 100; j++) begin
      tick();
      chk("timeout_wait", 32'(obs()), 32'(6'b010100));
    end
    tick();
    chk("timeout_pulse", 32'(obs()), 32'(6'b010001));
    tick();
    chk("timeout_after", 32'(obs()), 32'(6'b010000));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
